uart_rx_byte: RTL

- Receives 8N1 serial bytes on a single RX pin.
- Presents the last correctly framed byte as a held 8-bit value.
- Sits directly upstream of the two-digit Pmod seven-segment driver. o_data wires straight to the driver's 8-bit data input, so the display shows the last received byte as two hex digits.
- Also emits one-cycle strobes for a valid byte and for a framing error, for LEDs or debug.

---
 rtl/uart_rx_byte.sv | 88 ++++++++
 1 files changed

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver holding the last good byte, with valid and framing-error strobes
module uart_rx_byte #(
   parameter int CLOCK_HZ     = 125000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD
) (
   input  logic       i_clock_125MHz,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_valid,
   output logic       o_frame_error,
   output logic       o_busy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t          state, state_n;
   logic            rx_m, rx_s;
   logic [CW-1:0]   cnt;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            tick, done_ok, done_err;

   // two-flop synchronizer, idles high so reset never looks like a start bit
   always_ff @(posedge i_clock_125MHz or posedge i_reset)
      if (i_reset) {rx_m, rx_s} <= 2'b11;
      else         {rx_m, rx_s} <= {i_rx, rx_m};

   // state register
   always_ff @(posedge i_clock_125MHz or posedge i_reset)
      if (i_reset) state <= IDLE;
      else         state <= state_n;

   // next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE:      if (!rx_s) state_n = START;
         START:     if (tick) state_n = rx_s ? IDLE : DATA;
         DATA:      if (tick && bit_idx == 3'd7) state_n = STOP;
         STOP:      if (tick) state_n = rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // sample points and frame outcome
   always_comb begin
      tick     = (state == START) ? (cnt == HALF) : ((state == DATA || state == STOP) && cnt == FULL);
      done_ok  = (state == STOP) && tick && rx_s;
      done_err = (state == STOP) && tick && !rx_s;
      o_busy   = (state != IDLE);
   end

   // baud counter reloads at each sample point and is held clear while not timing bits
   always_ff @(posedge i_clock_125MHz or posedge i_reset)
      if (i_reset)                                   cnt <= '0;
      else if (tick || state == IDLE || state == WAIT_HIGH) cnt <= '0;
      else                                           cnt <= cnt + 1'b1;

   // data bits land LSB first at their own index
   always_ff @(posedge i_clock_125MHz or posedge i_reset)
      if (i_reset) begin
         bit_idx <= '0;
         shreg   <= '0;
      end else if (state == START) begin
         bit_idx <= '0;
      end else if (state == DATA && tick) begin
         shreg[bit_idx] <= rx_s;
         bit_idx        <= bit_idx + 1'b1;
      end

   // registered outputs: held byte and one-cycle strobes
   always_ff @(posedge i_clock_125MHz or posedge i_reset)
      if (i_reset) begin
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_frame_error <= 1'b0;
      end else begin
         o_data        <= done_ok ? shreg : o_data;
         o_valid       <= done_ok;
         o_frame_error <= done_err;
      end
endmodule
